ahb_slave_data_phase: RTL
=========================

Name: ahb_slave_data_phase

Overview:
- Downstream stage of the AHB address-mapping decoder in the payload slave.
- Captures the decoder's write_select, read_select and error flag on each accepted address phase.
- Runs the AHB data phase: returns OKAY or the two-cycle ERROR response, drives hreadyout, hresp and hrdata, and owns the payload/data-size register bank.
- Feeds register contents and a start pulse to the downstream payload engine.

Parameters:
- DATA_WIDTH, 32, width of hwdata/hrdata.
- PAYLOAD_LO_W, 32, width of payload low register (write_select 0).
- PAYLOAD_HI_W, 16, width of payload high register (write_select 1).
- SIZE_W, 16, width of data-size register (write_select 2).

Ports:
- hclk  in  1  AHB clock.
- hresetn  in  1  asynchronous active-low reset.
- hsel_x  in  1  slave select.
- hready  in  1  bus-level HREADY.
- htrans  in  2  transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ).
- hwrite  in  1  write transfer.
- hwdata  in  DATA_WIDTH  write data, valid in data phase.
- write_select  in  2  decoder write target.
- read_select  in  2  decoder read source.
- map_hresp  in  1  decoder error flag.
- err_status  in  16  system error status (read_select 0).
- hreadyout  out  1  slave ready.
- hresp  out  1  0 OKAY, 1 ERROR.
- hrdata  out  DATA_WIDTH  read data.
- payload_lo  out  PAYLOAD_LO_W  register.
- payload_hi  out  PAYLOAD_HI_W  register.
- data_size  out  SIZE_W  register.
- start  out  1  one-cycle pulse after a successful data_size write.

Behaviour:
- Reset: hreadyout=1, hresp=0, hrdata=0, all registers 0, start=0, FSM=IDLE, captured controls cleared (valid=0).
- Accept: an address phase is accepted when hsel_x && hready && htrans[1] at a hclk rising edge.
  - On accept, latch hwrite, write_select, read_select, map_hresp and set valid.
  - Otherwise valid=0 at any edge where hready=1.
  - IDLE/BUSY or unselected transfers give zero-wait OKAY and no register effect.
- FSM states: IDLE, DATA, ERR1, ERR2.
  - IDLE/DATA: if accept && map_hresp -> ERR1; else if accept -> DATA; else -> IDLE.
  - ERR1: hreadyout=0, hresp=1; unconditionally -> ERR2.
  - ERR2: hreadyout=1, hresp=1. Same transitions as IDLE; a new address phase sampled here is accepted normally even if the master cancels on the next cycle.
  - DATA and IDLE drive hreadyout=1, hresp=0.
- Write: in DATA with hreadyout=1 and latched hwrite, the register chosen by latched write_select loads hwdata[W-1:0] at the end of the cycle.
  - Errored transfers never write.
  - write_select 3 writes nothing.
- start: pulses for exactly one cycle, the cycle after a data_size write completes.
- Read: in DATA, hrdata is a combinational mux of latched read_select.
  - 0 -> zero-extended err_status.
  - 1 -> payload_lo.
  - 2 -> payload_hi.
  - 3 -> data_size.
  - hrdata=0 in IDLE/ERR1/ERR2 and for writes.
- Back-to-back: pipelined. A data-phase write and the next address phase occur in the same cycle. A read in the cycle after a write to the same register returns the new value.
- Reset mid-transfer: FSM returns to IDLE immediately; any pending write is dropped.

Optional Feature:
- AHB_READ_WAIT_EN defined: read data phases insert exactly one wait state.
  - Extra state RWAIT: hreadyout=0, hrdata is sampled into a register.
  - DATA then presents the registered hrdata with hreadyout=1.
  - Writes and errors are unchanged.
- Undefined: zero-wait reads as above.

Decomposition:
- ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ and HRESP_OKAY/HRESP_ERROR constants.
  - WSEL_PAYLOAD_LO/HI/DATA_SIZE and RSEL_ERR_STATUS/PAYLOAD_LO/HI/DATA_SIZE codes.
  - dp_state_t enum.
- One sub-module, ahb_payload_regs: register bank with write-enable, select, data in, three register outputs and the start pulse.

Test Plan:
- Reset: assert hresetn=0 mid-ERR1 -> hreadyout=1, hresp=0, registers 0, FSM IDLE next cycle.
- Write then read: NONSEQ write, write_select=0, hwdata=0xDEADBEEF; then read, read_select=1 -> payload_lo=0xDEADBEEF, hrdata=0xDEADBEEF, hresp=0, no wait states.
- Error: NONSEQ with map_hresp=1 -> cycle 1 hreadyout=0/hresp=1, cycle 2 hreadyout=1/hresp=1, no register change.
- start: data_size write with hwdata=0x0040 -> data_size=0x0040, start high for exactly one cycle.
- Back-to-back: write payload_hi=0x1234 followed by SEQ read of payload_hi -> hrdata=0x00001234 on the following cycle.
- Filtering: IDLE/BUSY transfers with map_hresp=1 -> OKAY, hreadyout=1. With AHB_READ_WAIT_EN, a read of err_status=0x0005 -> one hreadyout=0 cycle, then hrdata=0x00000005.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared constants, select codes and the data-phase state type for the
// payload slave's AHB data-phase stage.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [1:0] WSEL_PAYLOAD_LO = 2'd0;
  localparam logic [1:0] WSEL_PAYLOAD_HI = 2'd1;
  localparam logic [1:0] WSEL_DATA_SIZE  = 2'd2;

  localparam logic [1:0] RSEL_ERR_STATUS = 2'd0;
  localparam logic [1:0] RSEL_PAYLOAD_LO = 2'd1;
  localparam logic [1:0] RSEL_PAYLOAD_HI = 2'd2;
  localparam logic [1:0] RSEL_DATA_SIZE  = 2'd3;

  // ST_RWAIT is only reachable when the read wait-state option is built in.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_ERR1  = 3'd2,
    ST_ERR2  = 3'd3,
    ST_RWAIT = 3'd4
  } dp_state_t;

  // NONSEQ and SEQ are the only transfer types that carry a real transfer.
  function automatic logic is_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_payload_regs.sv
// Payload/data-size register bank. Loads the selected register from the
// write data when wr_en is high and pulses start the cycle after a
// data_size load.
module ahb_payload_regs
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int PAYLOAD_LO_W = 32,
  parameter int PAYLOAD_HI_W = 16,
  parameter int SIZE_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [1:0]              wr_sel,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic [PAYLOAD_LO_W-1:0] payload_lo,
  output logic [PAYLOAD_HI_W-1:0] payload_hi,
  output logic [SIZE_W-1:0]       data_size,
  output logic                    start
);

  // Register loads; select code 3 has no backing register and is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      payload_lo <= '0;
      payload_hi <= '0;
      data_size  <= '0;
    end else if (wr_en) begin
      case (wr_sel)
        WSEL_PAYLOAD_LO: payload_lo <= wr_data[PAYLOAD_LO_W-1:0];
        WSEL_PAYLOAD_HI: payload_hi <= wr_data[PAYLOAD_HI_W-1:0];
        WSEL_DATA_SIZE:  data_size  <= wr_data[SIZE_W-1:0];
        default: ;
      endcase
    end
  end

  // One-cycle start pulse following a completed data_size write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start <= 1'b0;
    end else begin
      start <= wr_en && (wr_sel == WSEL_DATA_SIZE);
    end
  end

endmodule

// File: rtl/ahb_slave_data_phase.sv
// AHB data-phase stage of the payload slave. Captures the decoder result on
// each accepted address phase, returns OKAY or the two-cycle ERROR response,
// drives read data and owns the payload register bank.
// Optional build macro: AHB_READ_WAIT_EN inserts one wait state on reads and
// presents registered read data.
module ahb_slave_data_phase
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int PAYLOAD_LO_W = 32,
  parameter int PAYLOAD_HI_W = 16,
  parameter int SIZE_W       = 16
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic                    hsel_x,
  input  logic                    hready,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [1:0]              write_select,
  input  logic [1:0]              read_select,
  input  logic                    map_hresp,
  input  logic [15:0]             err_status,
  output logic                    hreadyout,
  output logic                    hresp,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic [PAYLOAD_LO_W-1:0] payload_lo,
  output logic [PAYLOAD_HI_W-1:0] payload_hi,
  output logic [SIZE_W-1:0]       data_size,
  output logic                    start
);

  dp_state_t state;
  dp_state_t state_next;
  dp_state_t addr_next;

  logic       accept;
  logic       cap_valid;
  logic       cap_write;
  logic [1:0] cap_wsel;
  logic [1:0] cap_rsel;
  logic       cap_err;
  logic       reg_we;
  logic       read_phase;
  logic [DATA_WIDTH-1:0] read_mux;

  assign accept = hsel_x && hready && is_active(htrans);

  // Capture the decoder controls whenever the bus advances; valid drops on
  // any advancing edge without a real selected transfer.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      cap_valid <= 1'b0;
      cap_write <= 1'b0;
      cap_wsel  <= '0;
      cap_rsel  <= '0;
      cap_err   <= 1'b0;
    end else if (hready) begin
      cap_valid <= accept;
      if (accept) begin
        cap_write <= hwrite;
        cap_wsel  <= write_select;
        cap_rsel  <= read_select;
        cap_err   <= map_hresp;
      end
    end
  end

  // Destination for a freshly accepted address phase.
  always_comb begin
    addr_next = ST_IDLE;
    if (accept && map_hresp) begin
      addr_next = ST_ERR1;
    end else if (accept) begin
`ifdef AHB_READ_WAIT_EN
      addr_next = hwrite ? ST_DATA : ST_RWAIT;
`else
      addr_next = ST_DATA;
`endif
    end
  end

  // Data-phase state register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and response outputs; ERR1 stalls the bus, ERR2 completes
  // the error and may already accept the next address phase.
  always_comb begin
    state_next = ST_IDLE;
    hreadyout  = 1'b1;
    hresp      = HRESP_OKAY;
    case (state)
      ST_ERR1: begin
        hreadyout  = 1'b0;
        hresp      = HRESP_ERROR;
        state_next = ST_ERR2;
      end
      ST_ERR2: begin
        hresp      = HRESP_ERROR;
        state_next = addr_next;
      end
`ifdef AHB_READ_WAIT_EN
      ST_RWAIT: begin
        hreadyout  = 1'b0;
        state_next = ST_DATA;
      end
`endif
      default: begin
        state_next = addr_next;
      end
    endcase
  end

  assign reg_we     = (state == ST_DATA) && cap_valid && cap_write && !cap_err;
  assign read_phase = (state == ST_DATA) && cap_valid && !cap_write;

  // Read source selection from the captured read_select, zero-extended.
  always_comb begin
    read_mux = '0;
    case (cap_rsel)
      RSEL_ERR_STATUS: read_mux[15:0]             = err_status;
      RSEL_PAYLOAD_LO: read_mux[PAYLOAD_LO_W-1:0] = payload_lo;
      RSEL_PAYLOAD_HI: read_mux[PAYLOAD_HI_W-1:0] = payload_hi;
      RSEL_DATA_SIZE:  read_mux[SIZE_W-1:0]       = data_size;
      default: ;
    endcase
  end

`ifdef AHB_READ_WAIT_EN
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read data is sampled during the wait state and held for the DATA cycle.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rdata_q <= '0;
    end else if (state == ST_RWAIT) begin
      rdata_q <= read_mux;
    end
  end

  assign hrdata = read_phase ? rdata_q : '0;
`else
  assign hrdata = read_phase ? read_mux : '0;
`endif

  ahb_payload_regs #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PAYLOAD_LO_W(PAYLOAD_LO_W),
    .PAYLOAD_HI_W(PAYLOAD_HI_W),
    .SIZE_W      (SIZE_W)
  ) u_regs (
    .clk       (hclk),
    .rst_n     (hresetn),
    .wr_en     (reg_we),
    .wr_sel    (cap_wsel),
    .wr_data   (hwdata),
    .payload_lo(payload_lo),
    .payload_hi(payload_hi),
    .data_size (data_size),
    .start     (start)
  );

endmodule
